shift_deser: RTL and testbench



---
 rtl/shift_pkg.sv | 6 +
 rtl/deser_out_reg.sv | 37 +++
 rtl/shift_deser.sv | 100 ++++++++++
 tb/tb_shift_deser.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared state type and bit-order constants for the shift link blocks.
package shift_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} shift_deser_state_t;
   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: one-word output register with valid/ready handshake and a load port.
//   load/load_data : write a new word (only meaningful when free is high)
//   data_ready     : consumer accepts the held word
//   data_out       : held word, stable while data_valid && !data_ready
//   data_valid     : data_out holds an unconsumed word
//   free           : a load this cycle will not overwrite an unconsumed word
module deser_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             free
);
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   assign free       = !data_valid_q || data_ready;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   always_comb begin
      data_out_d   = load ? load_data : data_out_q;
      data_valid_d = load | (data_valid_q & ~data_ready);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end
endmodule

// File: rtl/shift_deser.sv
// shift_deser: framed serial-to-parallel deserializer with one-word output buffer.
//   ser_valid/ser_bit/ser_start : serial input; ser_start marks the first bit of a frame
//   msb_first                   : bit order, sampled with the start bit
//   data_out/data_valid/data_ready : word output handshake
//   busy     : frame in progress or completed word held back
//   overflow : sticky dropped-bit flag, cleared by ovf_clr (set wins)
module shift_deser
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_valid,
   input  logic             ser_bit,
   input  logic             ser_start,
   input  logic             msb_first,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overflow,
   input  logic             ovf_clr
);
   localparam int CW = $clog2(WIDTH + 1);
   shift_deser_state_t state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d, shifted, load_data;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic             dir_q, dir_d, overflow_q, overflow_d;
   logic             eff_dir, drop, load, out_free;
   // A start bit always shifts with the freshly sampled direction.
   assign eff_dir  = (state_q != SHIFT || ser_start) ? msb_first : dir_q;
   assign shifted  = (eff_dir == DIR_MSB_FIRST) ? {sreg_q[WIDTH-2:0], ser_bit}
                                                : {ser_bit, sreg_q[WIDTH-1:1]};
   assign cnt_inc  = cnt_q + CW'(1);
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      drop      = 1'b0;
      load      = 1'b0;
      load_data = sreg_q;
      case (state_q)
         IDLE: if (ser_valid && ser_start) begin
            dir_d   = msb_first;
            sreg_d  = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
         end
         SHIFT: if (ser_valid) begin
            dir_d  = ser_start ? msb_first : dir_q;
            sreg_d = shifted;
            cnt_d  = ser_start ? CW'(1) : cnt_inc;
            if (!ser_start && cnt_inc == CW'(WIDTH)) begin
               load      = out_free;
               load_data = shifted;
               state_d   = out_free ? IDLE : HOLD;
               cnt_d     = out_free ? '0 : cnt_inc;
            end
         end
         HOLD: begin
            // Bits arriving on the transfer edge are still dropped.
            drop    = ser_valid;
            load    = out_free;
            state_d = out_free ? IDLE : HOLD;
            cnt_d   = out_free ? '0 : cnt_q;
         end
         default: state_d = IDLE;
      endcase
      overflow_d = drop | (overflow_q & ~ovf_clr);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         cnt_q      <= '0;
         dir_q      <= DIR_LSB_FIRST;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         overflow_q <= overflow_d;
      end
   end
   deser_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_data),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .free       (out_free)
   );
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed stimulus with a frame-level reference model checked every cycle.
module tb_shift_deser;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst, ser_valid, ser_bit, ser_start, msb_first, data_ready, ovf_clr;
   logic [W-1:0] data_out;
   logic         data_valid, busy, overflow;
   int           checks = 0;
   int           errors = 0;
   logic         chk_en = 1'b0;

   always #5 clk = ~clk;

   shift_deser #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_valid  (ser_valid),
      .ser_bit    (ser_bit),
      .ser_start  (ser_start),
      .msb_first  (msb_first),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   // Reference model: bits of the current frame in arrival order, a pending
   // completed word, and the output buffer.
   logic [W-1:0] m_bits, m_pw, m_out, lw;
   int           m_n;
   logic         m_dir, m_in, m_pv, m_valid, m_ovf, m_free, m_load, m_set;

   function automatic logic [W-1:0] assemble(input logic [W-1:0] bits, input logic dir);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) w[dir ? W-1-i : i] = bits[i];
      return w;
   endfunction

   always @(posedge clk) begin
      m_free = !m_valid || data_ready;
      m_load = 1'b0;
      m_set  = 1'b0;
      lw     = '0;
      if (rst) begin
         m_n = 0; m_bits = '0; m_dir = 0; m_in = 0; m_pv = 0; m_pw = '0;
         m_out = '0; m_valid = 0; m_ovf = 0;
      end else begin
         if (m_pv) begin
            m_set = ser_valid;
            if (m_free) begin m_load = 1'b1; lw = m_pw; m_pv = 1'b0; end
         end else if (ser_valid && (ser_start || m_in)) begin
            if (ser_start) begin m_n = 0; m_dir = msb_first; m_in = 1'b1; end
            m_bits[m_n] = ser_bit;
            m_n++;
            if (m_n == W) begin
               m_in = 1'b0;
               if (m_free) begin m_load = 1'b1; lw = assemble(m_bits, m_dir); end
               else begin m_pv = 1'b1; m_pw = assemble(m_bits, m_dir); end
            end
         end
         if (m_load) begin m_out = lw; m_valid = 1'b1; end
         else if (m_valid && data_ready) m_valid = 1'b0;
         m_ovf = m_set | (m_ovf & !ovf_clr);
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      check("cyc_data_out", data_out, m_out);
      check("cyc_data_valid", W'(data_valid), W'(m_valid));
      check("cyc_busy", W'(busy), W'(m_in | m_pv));
      check("cyc_overflow", W'(overflow), W'(m_ovf));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s, input logic m);
      ser_valid = 1'b1; ser_bit = b; ser_start = s; msb_first = m;
      tick();
      ser_valid = 1'b0; ser_start = 1'b0; ser_bit = 1'b0;
   endtask

   task automatic send_seq(input logic [W-1:0] seq, input logic m);
      for (int i = 0; i < W; i++) send_bit(seq[W-1-i], i == 0, m);
   endtask

   initial begin
      logic [W-1:0] gap_seq;
      rst = 1; ser_valid = 0; ser_bit = 0; ser_start = 0; msb_first = 0;
      data_ready = 0; ovf_clr = 0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 0;
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", W'(data_valid), 8'h00);
      check("rst_busy", W'(busy), 8'h00);
      check("rst_ovf", W'(overflow), 8'h00);
      send_bit(1, 0, 1);
      check("stray_busy", W'(busy), 8'h00);
      check("stray_ovf", W'(overflow), 8'h00);
      data_ready = 1;
      send_seq(8'b00011110, 1);
      check("msb_valid", W'(data_valid), 8'h01);
      check("msb_data", data_out, 8'h1E);
      check("msb_model", m_out, 8'h1E);
      tick();
      check("msb_one_cycle", W'(data_valid), 8'h00);
      send_seq(8'b00011110, 0);
      check("lsb_data", data_out, 8'h78);
      check("lsb_model", m_out, 8'h78);
      tick();
      send_seq(8'b00011110, 1);
      data_ready = 0;
      check("bp_first", data_out, 8'h1E);
      send_seq(8'hA5, 1);
      check("bp_busy", W'(busy), 8'h01);
      check("bp_hold_data", data_out, 8'h1E);
      check("bp_no_ovf", W'(overflow), 8'h00);
      send_bit(1, 0, 1);
      send_bit(0, 1, 1);
      send_bit(1, 0, 1);
      check("bp_ovf", W'(overflow), 8'h01);
      check("bp_still_busy", W'(busy), 8'h01);
      data_ready = 1;
      tick();
      data_ready = 0;
      check("bp_release_data", data_out, 8'hA5);
      check("bp_release_valid", W'(data_valid), 8'h01);
      check("bp_release_busy", W'(busy), 8'h00);
      check("bp_model", m_out, 8'hA5);
      ovf_clr = 1;
      tick();
      ovf_clr = 0;
      check("ovf_cleared", W'(overflow), 8'h00);
      check("bp_stable", data_out, 8'hA5);
      data_ready = 1;
      tick();
      check("bp_consumed", W'(data_valid), 8'h00);
      send_bit(1, 1, 1);
      for (int i = 0; i < 3; i++) send_bit(0, 0, 1);
      send_seq(8'h3C, 1);
      check("restart_data", data_out, 8'h3C);
      check("restart_ovf", W'(overflow), 8'h00);
      tick();
      send_bit(1, 1, 1);
      for (int i = 0; i < 4; i++) send_bit(1, 0, 1);
      rst = 1;
      tick();
      rst = 0;
      check("midrst_data", data_out, 8'h00);
      check("midrst_valid", W'(data_valid), 8'h00);
      check("midrst_busy", W'(busy), 8'h00);
      check("midrst_ovf", W'(overflow), 8'h00);
      send_seq(8'h81, 1);
      check("post_rst_data", data_out, 8'h81);
      tick();
      gap_seq = 8'hC4;
      for (int i = 0; i < W; i++) begin
         if (i == W-1) check("gap_not_yet", W'(data_valid), 8'h00);
         send_bit(gap_seq[W-1-i], i == 0, 1);
         if (i < W-1) tick();
      end
      check("gap_valid", W'(data_valid), 8'h01);
      check("gap_data", data_out, 8'hC4);
      tick();
      check("gap_one_cycle", W'(data_valid), 8'h00);
      tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
